// File: rtl/runway_request_arbiter.sv
// runway_request_arbiter: queues plane clearance requests, locks a free runway per plane and forwards releases.
// Optional build macro EMERGENCY_SLOT_EN adds a 1-entry emergency slot served ahead of the FIFO.
module runway_request_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_plane_id,
    input  logic             req_emergency,
    input  logic             rel_valid,
    input  logic             rel_runway_id,
    input  logic [3:0]       rel_plane_id,
    input  logic [1:0]       runway_active,
    output logic             lock,
    output logic             unlock,
    output logic             runway_id,
    output logic [3:0]       plane_id,
    output logic             grant_valid,
    output logic [3:0]       grant_plane_id,
    output logic             grant_runway_id,
    output logic [CNT_W-1:0] queue_count,
    output logic             lock_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM} state_t;

    state_t           state_q, state_d;
    logic [3:0]       mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy_en_q;
    logic             acc, pop, fifo_push, fifo_pop, head_v;
    logic [3:0]       head_pl;
    logic             lock_q, lock_d, unlock_q, unlock_d, rw_q, rw_d;
    logic             gnt_q, gnt_d, gnt_rw_q, gnt_rw_d, err_q, err_d;
    logic             pend_q, pend_d, pend_rw_q, pend_rw_d;
    logic [3:0]       pl_q, pl_d, gnt_pl_q, gnt_pl_d, pend_pl_q, pend_pl_d;

    assign acc = req_valid & req_ready;

`ifdef EMERGENCY_SLOT_EN
    logic       slot_q;
    logic [3:0] slot_pl_q;

    assign req_ready   = rdy_en_q & (req_emergency ? !slot_q : cnt_q != FULL);
    assign fifo_push   = acc & !req_emergency;
    assign fifo_pop    = pop & !slot_q;
    assign head_v      = slot_q | (cnt_q != '0);
    assign head_pl     = slot_q ? slot_pl_q : mem_q[rd_ptr_q];
    assign queue_count = cnt_q + CNT_W'(slot_q);

    // Emergency slot: filled by an accepted emergency request, emptied when served ahead of the FIFO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= 1'b0;
            slot_pl_q <= '0;
        end else if (acc & req_emergency) begin
            slot_q    <= 1'b1;
            slot_pl_q <= req_plane_id;
        end else if (pop) begin
            slot_q    <= 1'b0;
        end
    end
`else
    logic unused_emergency;

    assign unused_emergency = req_emergency;
    assign req_ready        = rdy_en_q & (cnt_q != FULL);
    assign fifo_push        = acc;
    assign fifo_pop         = pop;
    assign head_v           = cnt_q != '0;
    assign head_pl          = mem_q[rd_ptr_q];
    assign queue_count      = cnt_q;
`endif

    // Request storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (fifo_push) mem_q[wr_ptr_q] <= req_plane_id;
    end

    // FIFO pointers and occupancy; ready comes up one cycle after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // Next state: releases win in IDLE, otherwise pop the head onto the lowest free runway
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        lock_d    = 1'b0;
        unlock_d  = 1'b0;
        rw_d      = rw_q;
        pl_d      = pl_q;
        gnt_d     = 1'b0;
        gnt_rw_d  = gnt_rw_q;
        gnt_pl_d  = gnt_pl_q;
        err_d     = err_q;
        pend_d    = pend_q;
        pend_rw_d = pend_rw_q;
        pend_pl_d = pend_pl_q;
        case (state_q)
            IDLE: begin
                if (pend_q || rel_valid) begin
                    unlock_d = 1'b1;
                    rw_d     = pend_q ? pend_rw_q : rel_runway_id;
                    pl_d     = pend_q ? pend_pl_q : rel_plane_id;
                    pend_d   = 1'b0;
                end else if (head_v && !(&runway_active)) begin
                    pop     = 1'b1;
                    lock_d  = 1'b1;
                    rw_d    = runway_active[0];
                    pl_d    = head_pl;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CONFIRM;
            default: begin
                state_d = IDLE;
                if (runway_active[rw_q]) begin
                    gnt_d    = 1'b1;
                    gnt_rw_d = rw_q;
                    gnt_pl_d = pl_q;
                end else begin
                    err_d = 1'b1;
                end
            end
        endcase
        if (rel_valid && (state_q != IDLE || pend_q)) begin
            pend_d    = 1'b1;
            pend_rw_d = rel_runway_id;
            pend_pl_d = rel_plane_id;
        end
    end

    // State, pending release and registered manager/tower outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lock_q    <= 1'b0;
            unlock_q  <= 1'b0;
            rw_q      <= 1'b0;
            pl_q      <= '0;
            gnt_q     <= 1'b0;
            gnt_rw_q  <= 1'b0;
            gnt_pl_q  <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            pend_rw_q <= 1'b0;
            pend_pl_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            unlock_q  <= unlock_d;
            rw_q      <= rw_d;
            pl_q      <= pl_d;
            gnt_q     <= gnt_d;
            gnt_rw_q  <= gnt_rw_d;
            gnt_pl_q  <= gnt_pl_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            pend_rw_q <= pend_rw_d;
            pend_pl_q <= pend_pl_d;
        end
    end

    assign lock            = lock_q;
    assign unlock          = unlock_q;
    assign runway_id       = rw_q;
    assign plane_id        = pl_q;
    assign grant_valid     = gnt_q;
    assign grant_plane_id  = gnt_pl_q;
    assign grant_runway_id = gnt_rw_q;
    assign lock_err        = err_q;
endmodule

// File: tb/tb_runway_request_arbiter.sv
// tb_runway_request_arbiter: scoreboard bench with a behavioural runway lock manager model
module tb_runway_request_arbiter;
    typedef struct packed {logic is_lock; logic rw; logic [3:0] pl;} cmd_t;
    typedef struct packed {logic rw; logic [3:0] pl;} gnt_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_plane_id = '0;
    logic       req_emergency = 1'b0;
    logic       rel_valid = 1'b0;
    logic       rel_runway_id = 1'b0;
    logic [3:0] rel_plane_id = '0;
    logic [1:0] runway_active = 2'b00;
    logic       lock, unlock, runway_id, grant_valid, grant_runway_id, lock_err;
    logic [3:0] plane_id, grant_plane_id;
    logic [2:0] queue_count;

    logic       mgr_stuck = 1'b0;
    logic       ra_load = 1'b0;
    logic [1:0] ra_val = 2'b00;

    cmd_t cmd_q[$];
    gnt_t gnt_q[$];
    cmd_t mon_c;
    gnt_t mon_g;
    int   checks = 0;
    int   errors = 0;

    runway_request_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_plane_id(req_plane_id),
        .req_emergency(req_emergency),
        .rel_valid(rel_valid), .rel_runway_id(rel_runway_id), .rel_plane_id(rel_plane_id),
        .runway_active(runway_active),
        .lock(lock), .unlock(unlock), .runway_id(runway_id), .plane_id(plane_id),
        .grant_valid(grant_valid), .grant_plane_id(grant_plane_id),
        .grant_runway_id(grant_runway_id),
        .queue_count(queue_count), .lock_err(lock_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lock manager model: sets a runway on lock, clears it on unlock, unless held idle
    always @(posedge clock) begin
        if (ra_load) runway_active <= ra_val;
        else if (!mgr_stuck) begin
            if (lock) runway_active[runway_id] <= 1'b1;
            if (unlock) runway_active[runway_id] <= 1'b0;
        end
    end

    // Scoreboard: compare every command and grant against the expected queues
    always @(negedge clock) begin
        if (reset_n) begin
            check("lock_unlock_excl", 32'(lock & unlock), 0);
            if (lock | unlock) begin
                check("cmd_expected", 32'(cmd_q.size() != 0), 1);
                if (cmd_q.size() != 0) begin
                    mon_c = cmd_q.pop_front();
                    check("cmd", 32'({lock, runway_id, plane_id}), 32'(mon_c));
                end
            end
            if (grant_valid) begin
                check("grant_expected", 32'(gnt_q.size() != 0), 1);
                if (gnt_q.size() != 0) begin
                    mon_g = gnt_q.pop_front();
                    check("grant", 32'({grant_runway_id, grant_plane_id}), 32'(mon_g));
                end
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (gnt_q.size() != 0 || cmd_q.size() != 0); i++) @(negedge clock);
        check({tag, "_grants"}, gnt_q.size(), 0);
        check({tag, "_cmds"}, cmd_q.size(), 0);
    endtask

    task automatic enqueue(input logic [3:0] pl, input logic emg);
        req_valid = 1'b1;
        req_plane_id = pl;
        req_emergency = emg;
        @(negedge clock);
        req_valid = 1'b0;
        req_emergency = 1'b0;
    endtask

    task automatic load_ra(input logic [1:0] v);
        ra_load = 1'b1;
        ra_val = v;
        @(negedge clock);
        ra_load = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_cmd", 32'({lock, unlock, runway_id, plane_id}), 0);
        check("rst_grant", 32'({grant_valid, grant_runway_id, grant_plane_id}), 0);
        check("rst_count", 32'(queue_count), 0);
        check("rst_err", 32'(lock_err), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 32'(req_ready), 1);

        // Both runways free: plane 5 locks runway 0 two cycles after acceptance
        cmd_q.push_back('{1'b1, 1'b0, 4'd5});
        gnt_q.push_back('{1'b0, 4'd5});
        enqueue(4'd5, 1'b0);
        check("t1_lock_early", 32'(lock), 0);
        @(negedge clock);
        check("t1_lock", 32'({lock, runway_id, plane_id}), 32'({1'b1, 1'b0, 4'd5}));
        drain("t1");

        // Runway 0 busy: plane 3 goes to runway 1
        check("t2_active", 32'(runway_active), 32'(2'b01));
        cmd_q.push_back('{1'b1, 1'b1, 4'd3});
        gnt_q.push_back('{1'b1, 4'd3});
        enqueue(4'd3, 1'b0);
        drain("t2");

        // Both busy: fill the FIFO, nothing may be locked
        for (int i = 1; i <= 4; i++) enqueue(4'(i), 1'b0);
        check("t3_count_full", 32'(queue_count), 4);
        check("t3_ready_full", 32'(req_ready), 0);
        enqueue(4'd6, 1'b0);
        check("t3_count_hold", 32'(queue_count), 4);
        check("t3_no_lock", 32'(lock), 0);
        cmd_q.push_back('{1'b1, 1'b0, 4'd1});
        gnt_q.push_back('{1'b0, 4'd1});
        load_ra(2'b10);
        drain("t3");
        check("t3_count_after", 32'(queue_count), 3);

        // Release of runway 1 in the cycle a lock for plane 2 would start
        cmd_q.push_back('{1'b0, 1'b1, 4'd7});
        cmd_q.push_back('{1'b1, 1'b0, 4'd2});
        cmd_q.push_back('{1'b1, 1'b1, 4'd3});
        gnt_q.push_back('{1'b0, 4'd2});
        gnt_q.push_back('{1'b1, 4'd3});
        ra_load = 1'b1;
        ra_val = 2'b10;
        @(negedge clock);
        ra_load = 1'b0;
        rel_valid = 1'b1;
        rel_runway_id = 1'b1;
        rel_plane_id = 4'd7;
        @(negedge clock);
        rel_valid = 1'b0;
        check("t4_unlock_first", 32'({lock, unlock}), 32'(2'b01));
        drain("t4");

        // Manager held idle: lock for plane 4 is never confirmed
        mgr_stuck = 1'b1;
        cmd_q.push_back('{1'b1, 1'b0, 4'd4});
        load_ra(2'b00);
        for (int i = 0; i < 20 && !lock_err; i++) @(negedge clock);
        check("t5_err_set", 32'(lock_err), 1);
        repeat (5) @(negedge clock);
        check("t5_err_sticky", 32'(lock_err), 1);
        check("t5_count", 32'(queue_count), 0);
        drain("t5");
        mgr_stuck = 1'b0;
        load_ra(2'b11);

`ifdef EMERGENCY_SLOT_EN
        // Emergency plane 9 overtakes queued planes 1 and 2
        enqueue(4'd1, 1'b0);
        enqueue(4'd2, 1'b0);
        enqueue(4'd9, 1'b1);
        check("em_count", 32'(queue_count), 3);
        cmd_q.push_back('{1'b1, 1'b0, 4'd9});
        cmd_q.push_back('{1'b1, 1'b1, 4'd1});
        gnt_q.push_back('{1'b0, 4'd9});
        gnt_q.push_back('{1'b1, 4'd1});
        load_ra(2'b00);
        drain("em");
        check("em_count_after", 32'(queue_count), 1);
`endif

        // Mid-operation reset drops queued requests and clears the error
        enqueue(4'd8, 1'b0);
        enqueue(4'd9, 1'b0);
        check("mr_count_before", 32'(queue_count), 2);
        reset_n = 1'b0;
        @(negedge clock);
        check("mr_count", 32'(queue_count), 0);
        check("mr_err", 32'(lock_err), 0);
        check("mr_ready", 32'(req_ready), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("mr_ready_after", 32'(req_ready), 1);
        load_ra(2'b00);
        repeat (6) @(negedge clock);
        check("mr_no_lock", 32'(lock), 0);

        check("end_cmdq", cmd_q.size(), 0);
        check("end_gntq", gnt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
